speed_frame_packer: RTL
=======================

// Module: speed_frame_packer
// PURPOSE
//   Sits between non_stop_ETC and the UART TX FIFO. On each speed measurement
//   (done pulse) it converts the binary speed to 5 decimal ASCII digits and
//   pushes one fixed 8-byte frame "S ddddd CR LF" into uart_fifo. It honours
//   FIFO full backpressure, so the host terminal receives human-readable speed records.
// PARAMETERS
//   WIDTH_SPEED  14     speed input width; legal range 1..16, and values >16 are an elaboration error
//   DATA_SIZE    8      FIFO byte width; must be 8
//   HEADER       8'h53  first byte of every frame ('S')
// PORTS
//   clk         in   1            single system clock; all logic on posedge
//   reset       in   1            asynchronous, active-high reset
//   done        in   1            1-cycle pulse: speed valid this cycle
//   speed       in   WIDTH_SPEED  unsigned measured speed
//   full        in   1            TX FIFO full
//   write       out  1            FIFO push strobe, 1 cycle per byte
//   data        out  DATA_SIZE    byte presented with write
//   busy        out  1            high from accept until frame complete
//   frame_sent  out  1            1-cycle pulse on the cycle the last byte (LF) is written
//   drop_cnt    out  8            saturating count of rejected done pulses
// BEHAVIOUR
//   Reset values: write=0, data=0, busy=0, frame_sent=0, drop_cnt=0, state=IDLE, BCD regs=0.
//   FSM states and transitions:
//     IDLE    -> CONVERT  when done=1. speed is latched at that edge, and busy goes high on the next cycle.
//     CONVERT -> SEND     after exactly WIDTH_SPEED cycles of shift-add-3 (double dabble),
//                         one input bit per cycle, MSB first, producing 5 BCD digits.
//     SEND    -> IDLE     after byte index 7 is written.
//   Frame byte order: HEADER, d4, d3, d2, d1, d0 (each 8'h30+digit, leading zeros kept), 8'h0D, 8'h0A.
//   SEND timing:
//     - write is asserted combinationally from the registered state: write = (state==SEND) && !full.
//     - data holds the current byte whenever state==SEND, including while stalled.
//     - The byte index advances only on cycles where write=1.
//   Latency: done sampled at edge k -> CONVERT for cycles k+1..k+W -> first write in cycle k+W+1
//     if !full. With no stall, the last write is in cycle k+W+8. frame_sent is high in that
//     same cycle, and the FSM is in IDLE at k+W+9.
//   Backpressure: full=1 while in SEND forces write=0. Byte index and data hold. There is no
//     timeout; a stall may last indefinitely.
//   Overlap and boundary conditions:
//     - done is accepted only in IDLE.
//     - done while busy is dropped and drop_cnt increments; drop_cnt saturates at 255.
//       The frame in progress is unaffected.
//     - done in the same cycle as the LF write is dropped, because the FSM is still in SEND.
//     - speed=0 produces "S00000\r\n".
//     - The maximum speed for W=14 is 16383, producing "S16383\r\n".
//   full is ignored outside SEND.
//   Reset asserted mid-conversion or mid-frame aborts immediately to reset values.
//     Bytes already pushed remain in the FIFO, and no further bytes of that frame are emitted.
// STRUCTURE
//   Package speed_frame_pkg:
//     - state enum {IDLE, CONVERT, SEND}
//     - FRAME_LEN=8
//     - ASCII_ZERO=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A
//   Sub-module bin2bcd_seq (clk, reset, start, bin, busy, bcd[19:0], valid): iterative
//     double dabble, WIDTH_SPEED cycles, reusable by other report formatters.
//   Top level holds the FSM, byte index counter (3 bits), byte mux and drop counter.
// TESTING
//   1. W=14, speed=1234, done pulse, full=0 -> writes in 8 consecutive cycles starting k+15:
//      53 30 31 32 33 34 0D 0A. frame_sent is high with 0A, and busy is low at k+23.
//   2. speed=16383 -> 53 31 36 33 38 33 0D 0A. speed=0 -> 53 30 30 30 30 30 0D 0A.
//   3. full=1 for 3 cycles when byte index=3 -> write low for 3 cycles with data held at d2.
//      The stream resumes, the frame is intact, and frame_sent is 3 cycles later than case 1.
//   4. done pulses at k and k+5 (during CONVERT) and on the LF cycle -> one frame only, drop_cnt=2.
//      300 dropped pulses leave drop_cnt=255.
//   5. reset asserted during SEND at byte index 4, held 2 cycles, then done with speed=42
//      -> all outputs go to reset values asynchronously. The next frame is 53 30 30 30 34 32 0D 0A.
//   6. Random speeds with random full -> the bench decodes the byte stream and checks each
//      frame against a decimal model. No write may occur while full=1.

Source files
------------

// File: rtl/speed_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module  : speed_frame_pkg
// Purpose : Shared types, frame constants and the BCD step for speed reports.
// Rev     : 1.0
// ============================================================================
package speed_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SEND    = 2'd2
  } state_t;

  localparam int         FRAME_LEN  = 8;
  localparam int         BCD_DIGITS = 5;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift in bit_in.
  function automatic logic [4*BCD_DIGITS-1:0] bcd_step(input logic [4*BCD_DIGITS-1:0] bcd,
                                                       input logic                    bit_in);
    logic [4*BCD_DIGITS-1:0] adj;
    adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[4*BCD_DIGITS-2:0], bit_in};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq
// Purpose : Iterative binary to 5-digit BCD converter, one bit per cycle.
// Rev     : 1.0
// ============================================================================
module bin2bcd_seq
  import speed_frame_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic [19:0]      bcd,
  output logic             valid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] r_shift;
  logic [19:0]      r_bcd;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_valid;

  // The MSB is absorbed on the load edge, so a conversion spans WIDTH edges in total.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_busy) begin
        r_bcd   <= bcd_step(r_bcd, r_shift[WIDTH-1]);
        r_shift <= r_shift << 1;
        r_cnt   <= r_cnt - C_CNT_ONE;
        if (r_cnt == C_CNT_ONE) begin
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
        end
      end else if (start) begin
        r_bcd   <= {19'd0, bin[WIDTH-1]};
        r_shift <= bin << 1;
        r_cnt   <= C_CNT_INIT;
        if (WIDTH == 1) r_valid <= 1'b1;
        else            r_busy  <= 1'b1;
      end
    end
  end

  assign busy  = r_busy;
  assign bcd   = r_bcd;
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/speed_frame_packer.sv
`default_nettype none
// ============================================================================
// Module  : speed_frame_packer
// Purpose : Formats each speed sample as "Sddddd\r\n" and pushes it to the TX FIFO.
// Rev     : 1.0
// ============================================================================
module speed_frame_packer
  import speed_frame_pkg::*;
#(
  parameter int         WIDTH_SPEED = 14,
  parameter int         DATA_SIZE   = 8,
  parameter logic [7:0] HEADER      = 8'h53
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   done,
  input  logic [WIDTH_SPEED-1:0] speed,
  input  logic                   full,
  output logic                   write,
  output logic [DATA_SIZE-1:0]   data,
  output logic                   busy,
  output logic                   frame_sent,
  output logic [7:0]             drop_cnt
);

  if (WIDTH_SPEED < 1 || WIDTH_SPEED > 16) begin : g_bad_width
    $error("speed_frame_packer: WIDTH_SPEED must be 1..16");
  end
  if (DATA_SIZE != 8) begin : g_bad_data_size
    $error("speed_frame_packer: DATA_SIZE must be 8");
  end

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [7:0]       r_drop;
  logic             w_start;
  logic             w_conv_busy;
  logic             w_conv_valid;
  logic [19:0]      w_bcd;
  logic             w_write;
  logic [DATA_SIZE-1:0] w_byte;

  assign w_start = (r_state == IDLE) && done && !w_conv_busy;

  bin2bcd_seq #(
    .WIDTH (WIDTH_SPEED)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .bin   (speed),
    .busy  (w_conv_busy),
    .bcd   (w_bcd),
    .valid (w_conv_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_drop  <= 8'd0;
    end else begin
      if (done && (r_state != IDLE) && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      case (r_state)
        IDLE: begin
          r_idx <= 3'd0;
          if (w_start) r_state <= CONVERT;
        end
        CONVERT: if (w_conv_valid) r_state <= SEND;
        SEND: begin
          if (w_write) begin
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'(FRAME_LEN - 1)) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Digits are read straight from the converter, which holds its result until the next start.
  always_comb begin
    w_byte = '0;
    case (r_idx)
      3'd0:    w_byte = HEADER;
      3'd1:    w_byte = ASCII_ZERO | {4'h0, w_bcd[19:16]};
      3'd2:    w_byte = ASCII_ZERO | {4'h0, w_bcd[15:12]};
      3'd3:    w_byte = ASCII_ZERO | {4'h0, w_bcd[11:8]};
      3'd4:    w_byte = ASCII_ZERO | {4'h0, w_bcd[7:4]};
      3'd5:    w_byte = ASCII_ZERO | {4'h0, w_bcd[3:0]};
      3'd6:    w_byte = ASCII_CR;
      default: w_byte = ASCII_LF;
    endcase
  end

  assign w_write    = (r_state == SEND) && !full;
  assign write      = w_write;
  assign data       = (r_state == SEND) ? w_byte : '0;
  assign busy       = (r_state != IDLE);
  assign frame_sent = w_write && (r_idx == 3'(FRAME_LEN - 1));
  assign drop_cnt   = r_drop;

endmodule
`default_nettype wire
